mem_arbiter_rr: RTL and testbench

- N-client arbiter in front of the single-port frame-buffer BRAM.
- Parametrised successor to the fixed 3-client fetch/rectangle arbiter.
- Round-robin fairness across all clients, plus a bounded-latency guarantee for one urgent client (the display fetcher).
- Read data is returned by broadcast with a one-hot per-client strobe after a configurable read latency; reads are fully pipelined at one per cycle.

---
 rtl/mem_arbiter_rr.sv | 130 +++++++++++++
 tb/tb_mem_arbiter_rr.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter for the single-port frame-buffer BRAM, with a bounded wait
// for one urgent client and one-hot broadcast of read data after RD_LAT cycles.
module mem_arbiter_rr #(
  parameter int NUM_CLIENTS   = 4,
  parameter int ADDR_W        = 17,
  parameter int DATA_W        = 32,
  parameter int WBEN_W        = 4,
  parameter int RD_LAT        = 2,
  parameter int URGENT_CLIENT = 0,
  parameter int URGENT_GAP    = 2
) (
  input  logic                          clk,
  input  logic                          rst_,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] req_wrdata,
  input  logic [NUM_CLIENTS*WBEN_W-1:0] req_op,
  input  logic [NUM_CLIENTS-1:0]        req_rts,
  output logic [NUM_CLIENTS-1:0]        req_rtr,
  output logic                          mem_en,
  output logic [WBEN_W-1:0]             wben,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_data_out,
  input  logic [DATA_W-1:0]             mem_data_in,
  output logic [DATA_W-1:0]             bcast_data,
  output logic [NUM_CLIENTS-1:0]        bcast_xfc
);

  localparam int PW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int SW = (URGENT_GAP > 0) ? $clog2(URGENT_GAP + 1) : 1;

  logic [PW-1:0]          ptr_q, ptr_d;
  logic [SW-1:0]          starve_q, starve_d;
  logic [NUM_CLIENTS-1:0] grant;
  logic [NUM_CLIENTS-1:0] xfc;
  logic                   anyXfc;
  logic                   forceUrgent;
  logic                   found;
  logic [PW:0]            idx;
  logic [ADDR_W-1:0]      selAddr;
  logic [DATA_W-1:0]      selData;
  logic [WBEN_W-1:0]      selOp;

  logic                   memEn_q;
  logic [WBEN_W-1:0]      wben_q;
  logic [ADDR_W-1:0]      memAddr_q;
  logic [DATA_W-1:0]      memData_q;
  logic [NUM_CLIENTS-1:0] pipe_q [RD_LAT+1];

  assign forceUrgent = (URGENT_GAP != 0) && req_rts[URGENT_CLIENT] &&
                       (starve_q == SW'(URGENT_GAP));

  // A forced urgent grant leaves ptr alone so the round-robin order resumes intact.
  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    if (rst_) begin
      if (forceUrgent) begin
        grant[URGENT_CLIENT] = 1'b1;
      end else begin
        for (int i = 0; i < NUM_CLIENTS; i++) begin
          idx = {1'b0, ptr_q} + (PW+1)'(i);
          if (idx >= (PW+1)'(NUM_CLIENTS)) idx = idx - (PW+1)'(NUM_CLIENTS);
          if (!found && req_rts[idx[PW-1:0]]) begin
            found = 1'b1;
            grant[idx[PW-1:0]] = 1'b1;
            ptr_d = (idx == (PW+1)'(NUM_CLIENTS-1)) ? '0 : idx[PW-1:0] + 1'b1;
          end
        end
      end
    end
  end

  assign req_rtr = grant;
  assign xfc     = req_rts & grant;
  assign anyXfc  = |xfc;

  always_comb begin
    starve_d = '0;
    if (URGENT_GAP != 0 && req_rts[URGENT_CLIENT] && !grant[URGENT_CLIENT]) begin
      starve_d = (starve_q == SW'(URGENT_GAP)) ? starve_q : starve_q + 1'b1;
    end
  end

  always_comb begin
    selAddr = '0;
    selData = '0;
    selOp   = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      if (xfc[k]) begin
        selAddr = req_addr[k*ADDR_W +: ADDR_W];
        selData = req_wrdata[k*DATA_W +: DATA_W];
        selOp   = req_op[k*WBEN_W +: WBEN_W];
      end
    end
  end

  // The final pipeline stage is the strobe, landing with valid mem_data_in.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      ptr_q     <= '0;
      starve_q  <= '0;
      memEn_q   <= 1'b0;
      wben_q    <= '0;
      memAddr_q <= '0;
      memData_q <= '0;
      for (int i = 0; i <= RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      ptr_q    <= ptr_d;
      starve_q <= starve_d;
      memEn_q  <= anyXfc;
      wben_q   <= anyXfc ? selOp : '0;
      if (anyXfc) begin
        memAddr_q <= selAddr;
        memData_q <= selData;
      end
      pipe_q[0] <= (anyXfc && selOp == '0) ? xfc : '0;
      for (int i = 1; i <= RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign mem_en       = memEn_q;
  assign wben         = wben_q;
  assign mem_addr     = memAddr_q;
  assign mem_data_out = memData_q;
  assign bcast_xfc    = pipe_q[RD_LAT];
  assign bcast_data   = mem_data_in;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench: u0 has forcing disabled (pure round-robin), u2 uses a gap of 2.
module tb_mem_arbiter_rr;

  logic        clk;
  logic        rst_;
  logic [67:0] reqAddr;
  logic [127:0] reqWrData;
  logic [15:0] op;
  logic [3:0]  rts0, rts2;
  logic [31:0] memDataIn;

  logic [3:0]  rtr0, rtr2;
  logic        memEn0, memEn2;
  logic [3:0]  wben0, wben2;
  logic [16:0] memAddr0, memAddr2;
  logic [31:0] memDataOut0, memDataOut2;
  logic [31:0] bcastData0, bcastData2;
  logic [3:0]  bcastXfc0, bcastXfc2;

  int passed = 0;
  int total  = 0;

  mem_arbiter_rr #(.URGENT_GAP(0)) u0 (
    .clk(clk), .rst_(rst_), .req_addr(reqAddr), .req_wrdata(reqWrData),
    .req_op(op), .req_rts(rts0), .req_rtr(rtr0), .mem_en(memEn0),
    .wben(wben0), .mem_addr(memAddr0), .mem_data_out(memDataOut0),
    .mem_data_in(memDataIn), .bcast_data(bcastData0), .bcast_xfc(bcastXfc0)
  );

  mem_arbiter_rr #(.URGENT_GAP(2)) u2 (
    .clk(clk), .rst_(rst_), .req_addr(reqAddr), .req_wrdata(reqWrData),
    .req_op(op), .req_rts(rts2), .req_rtr(rtr2), .mem_en(memEn2),
    .wben(wben2), .mem_addr(memAddr2), .mem_data_out(memDataOut2),
    .mem_data_in(memDataIn), .bcast_data(bcastData2), .bcast_xfc(bcastXfc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the edge; checks follow 1 unit later.
  task automatic applyStimulus(input logic [3:0] r0, input logic [3:0] r2, input logic [15:0] o);
    @(posedge clk);
    #1;
    rts0 = r0;
    rts2 = r2;
    op   = o;
    #1;
  endtask

  initial begin
    rst_      = 1'b0;
    rts0      = 4'hF;
    rts2      = 4'hF;
    op        = 16'hFFFF;
    reqAddr   = {17'h00103, 17'h00123, 17'h00101, 17'h00100};
    reqWrData = {32'h000000A3, 32'h000000A2, 32'h000000A1, 32'h000000A0};
    memDataIn = 32'hDEADBEEF;

    repeat (3) @(posedge clk);
    #2;
    checkOutput("rst_rtr0", 32'(rtr0), 32'h0);
    checkOutput("rst_rtr2", 32'(rtr2), 32'h0);
    checkOutput("rst_memen", 32'(memEn0), 32'h0);
    checkOutput("rst_wben", 32'(wben0), 32'h0);
    checkOutput("rst_addr", 32'(memAddr0), 32'h0);
    checkOutput("rst_bcast", 32'(bcastXfc0), 32'h0);

    @(posedge clk);
    #1;
    rst_ = 1'b1;
    #1;
    checkOutput("first_rtr0", 32'(rtr0), 32'h1);
    checkOutput("first_rtr2", 32'(rtr2), 32'h1);

    applyStimulus(4'hF, 4'hF, 16'hFFFF);
    checkOutput("rr1_rtr0", 32'(rtr0), 32'h2);
    checkOutput("urg1_rtr2", 32'(rtr2), 32'h2);
    checkOutput("wr_memen", 32'(memEn0), 32'h1);
    checkOutput("wr_wben", 32'(wben0), 32'hF);
    checkOutput("wr_addr", 32'(memAddr0), 32'h100);
    checkOutput("wr_data", memDataOut0, 32'hA0);
    checkOutput("wr_bcast1", 32'(bcastXfc0), 32'h0);

    applyStimulus(4'hF, 4'hF, 16'hFFFF);
    checkOutput("rr2_rtr0", 32'(rtr0), 32'h4);
    checkOutput("urg2_rtr2", 32'(rtr2), 32'h4);
    checkOutput("wr_addr2", 32'(memAddr0), 32'h101);

    applyStimulus(4'hF, 4'hF, 16'hFFFF);
    checkOutput("rr3_rtr0", 32'(rtr0), 32'h8);
    checkOutput("urg_forced", 32'(rtr2), 32'h1);

    applyStimulus(4'hF, 4'hF, 16'hFFFF);
    checkOutput("rr4_rtr0", 32'(rtr0), 32'h1);
    checkOutput("urg4_rtr2", 32'(rtr2), 32'h8);
    checkOutput("wr_bcast4", 32'(bcastXfc0), 32'h0);

    applyStimulus(4'hF, 4'hF, 16'hFFFF);
    checkOutput("rr5_rtr0", 32'(rtr0), 32'h2);
    checkOutput("urg5_rtr2", 32'(rtr2), 32'h1);

    applyStimulus(4'b0100, 4'h0, 16'hF0FF);
    checkOutput("rd_rtr", 32'(rtr0), 32'h4);
    checkOutput("idle_rtr2", 32'(rtr2), 32'h0);

    applyStimulus(4'h0, 4'h0, 16'hFFFF);
    checkOutput("rd_addr", 32'(memAddr0), 32'h00123);
    checkOutput("rd_wben", 32'(wben0), 32'h0);
    checkOutput("rd_memen", 32'(memEn0), 32'h1);
    checkOutput("rd_norr", 32'(rtr0), 32'h0);
    checkOutput("rd_bcast1", 32'(bcastXfc0), 32'h0);

    applyStimulus(4'h0, 4'h0, 16'hFFFF);
    memDataIn = 32'hCAFEF00D;
    checkOutput("idle_memen", 32'(memEn0), 32'h0);
    checkOutput("hold_addr", 32'(memAddr0), 32'h00123);
    checkOutput("rd_bcast2", 32'(bcastXfc0), 32'h0);

    applyStimulus(4'h0, 4'h0, 16'hFFFF);
    checkOutput("rd_bcast3", 32'(bcastXfc0), 32'h4);
    checkOutput("rd_bdata", bcastData0, 32'hCAFEF00D);

    applyStimulus(4'b0010, 4'h0, 16'hFF0F);
    checkOutput("p0_rtr", 32'(rtr0), 32'h2);
    checkOutput("p0_bcast", 32'(bcastXfc0), 32'h0);
    applyStimulus(4'b0100, 4'h0, 16'hFFFF);
    checkOutput("p1_rtr", 32'(rtr0), 32'h4);
    applyStimulus(4'b1000, 4'h0, 16'h0FFF);
    checkOutput("p2_rtr", 32'(rtr0), 32'h8);
    checkOutput("p2_bcast", 32'(bcastXfc0), 32'h0);
    applyStimulus(4'h0, 4'h0, 16'hFFFF);
    checkOutput("p3_bcast", 32'(bcastXfc0), 32'h2);
    applyStimulus(4'h0, 4'h0, 16'hFFFF);
    checkOutput("p4_bcast", 32'(bcastXfc0), 32'h0);
    applyStimulus(4'h0, 4'h0, 16'hFFFF);
    checkOutput("p5_bcast", 32'(bcastXfc0), 32'h8);
    applyStimulus(4'h0, 4'h0, 16'hFFFF);
    checkOutput("p6_bcast", 32'(bcastXfc0), 32'h0);

    applyStimulus(4'b0001, 4'h0, 16'hFFF0);
    checkOutput("m0_rtr", 32'(rtr0), 32'h1);
    applyStimulus(4'h0, 4'h0, 16'hFFFF);
    checkOutput("m1_memen", 32'(memEn0), 32'h1);
    @(posedge clk);
    #1;
    rst_ = 1'b0;
    #1;
    checkOutput("m2_bcast", 32'(bcastXfc0), 32'h0);
    checkOutput("m2_memen", 32'(memEn0), 32'h0);
    checkOutput("m2_addr", 32'(memAddr0), 32'h0);
    @(posedge clk);
    #1;
    rst_ = 1'b1;
    #1;
    checkOutput("m3_bcast", 32'(bcastXfc0), 32'h0);
    applyStimulus(4'h0, 4'h0, 16'hFFFF);
    checkOutput("m4_bcast", 32'(bcastXfc0), 32'h0);
    checkOutput("m4_memen", 32'(memEn0), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
